// File: rtl/fft_power_avg.sv
// Streaming |X|^2 power detector for FFT bins with optional per-bin averaging over
// 2^n consecutive frames. Three-stage pipeline sharing one backpressure enable.
module fft_power_avg #(
    parameter int DW           = 16,
    parameter int FRAME_LEN    = 1024,
    parameter int MAX_AVG_LOG2 = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [2*DW-1:0]                    i_data,
    input  logic                               i_data_valid,
    input  logic                               i_data_last,
    output logic                               o_data_ready,
    input  logic                               i_mode,
    input  logic [$clog2(MAX_AVG_LOG2+1)-1:0]  i_avg_log2,
    output logic [2*DW-1:0]                    o_data,
    output logic                               o_data_valid,
    output logic                               o_data_last,
    input  logic                               i_data_ready,
    output logic                               o_frame_err
);

    localparam int PW = 2 * DW;
    localparam int AW = PW + MAX_AVG_LOG2;
    localparam int BW = $clog2(FRAME_LEN);
    localparam int NW = $clog2(MAX_AVG_LOG2 + 1);
    localparam int FW = MAX_AVG_LOG2;

    localparam logic [BW-1:0] LAST_BIN   = BW'(FRAME_LEN - 1);
    localparam logic [BW-1:0] ZERO_BIN   = BW'(0);
    localparam logic [BW-1:0] BIN_ONE    = BW'(1);
    localparam logic [FW-1:0] ZERO_FRAME = FW'(0);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
    localparam logic [FW:0]   SPAN_ONE   = (FW+1)'(1);
    localparam logic [NW-1:0] MAX_N      = NW'(MAX_AVG_LOG2);
    localparam logic [NW-1:0] ZERO_N     = NW'(0);

    typedef enum logic {S_PASS, S_ACC} state_t;

    state_t          state_r;
    logic [NW-1:0]   n_r;
    logic [BW-1:0]   bin_r;
    logic [FW-1:0]   frame_r;

    logic            adv_s, accept_s, boundary_s, at_end_s, frame_err_s;
    logic            mode_acc_s, last_frame_s, emit_s;
    logic [NW-1:0]   n_req_s, n_cur_s;
    logic [FW:0]     frame_span_s;
    logic [FW-1:0]   frame_top_s;
    logic signed [DW-1:0] re_s, im_s;

    logic            s1_valid_r, s1_acc_r, s1_first_r, s1_emit_r, s1_last_r;
    logic [PW-2:0]   s1_re_sq_r, s1_im_sq_r;
    logic [AW-1:0]   s1_rd_r;
    logic [BW-1:0]   s1_bin_r;
    logic [NW-1:0]   s1_n_r;

    logic            s2_valid_r, s2_acc_r, s2_first_r, s2_emit_r, s2_last_r;
    logic [PW-1:0]   s2_p_r;
    logic [AW-1:0]   s2_rd_r;
    logic [BW-1:0]   s2_bin_r;
    logic [NW-1:0]   s2_n_r;

    logic [AW-1:0]   acc_s;
    logic [PW-1:0]   out_s;

    logic [AW-1:0]   mem_r [FRAME_LEN];

    // Handshake and frame-boundary decode; mode/depth only change at bin 0 of frame 0.
    always_comb begin
        adv_s       = !o_data_valid || i_data_ready;
        accept_s    = i_data_valid && adv_s;
        boundary_s  = (bin_r == ZERO_BIN) && (frame_r == ZERO_FRAME);
        at_end_s    = (bin_r == LAST_BIN);
        frame_err_s = (i_data_last != at_end_s);
        n_req_s     = (i_avg_log2 > MAX_N) ? MAX_N : i_avg_log2;
        if (boundary_s) begin
            mode_acc_s = i_mode;
            n_cur_s    = n_req_s;
        end else begin
            mode_acc_s = (state_r == S_ACC);
            n_cur_s    = n_r;
        end
        frame_span_s = SPAN_ONE << n_cur_s;
        frame_top_s  = FW'(frame_span_s - SPAN_ONE);
        last_frame_s = (frame_r == frame_top_s);
        emit_s       = !mode_acc_s || last_frame_s;
        re_s         = i_data[DW-1:0];
        im_s         = i_data[PW-1:DW];
    end

    assign o_data_ready = adv_s;

    // Mode FSM, bin/frame counters and framing-error pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r     <= S_PASS;
            n_r         <= ZERO_N;
            bin_r       <= ZERO_BIN;
            frame_r     <= ZERO_FRAME;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= accept_s && frame_err_s;
            if (accept_s) begin
                if (boundary_s) begin
                    state_r <= i_mode ? S_ACC : S_PASS;
                    n_r     <= n_req_s;
                end
                if (frame_err_s) begin
                    bin_r   <= ZERO_BIN;
                    frame_r <= ZERO_FRAME;
                end else if (at_end_s) begin
                    bin_r   <= ZERO_BIN;
                    frame_r <= (mode_acc_s && !last_frame_s) ? frame_r + FRAME_ONE : ZERO_FRAME;
                end else begin
                    bin_r   <= bin_r + BIN_ONE;
                end
            end
        end
    end

    // Stage valid bits; all stages move together on adv.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r <= accept_s;
            s2_valid_r <= s1_valid_r;
        end
    end

    // Stage 1/2 datapath: squares and RAM read, then the exact power sum.
    always_ff @(posedge i_clk) begin
        if (adv_s) begin
            if (accept_s) begin
                s1_re_sq_r <= (PW-1)'(re_s * re_s);
                s1_im_sq_r <= (PW-1)'(im_s * im_s);
                s1_rd_r    <= mem_r[bin_r];
                s1_bin_r   <= bin_r;
                s1_acc_r   <= mode_acc_s;
                s1_first_r <= (frame_r == ZERO_FRAME);
                s1_emit_r  <= emit_s;
                s1_last_r  <= mode_acc_s ? at_end_s : i_data_last;
                s1_n_r     <= n_cur_s;
            end
            s2_p_r     <= PW'(s1_re_sq_r) + PW'(s1_im_sq_r);
            s2_rd_r    <= s1_rd_r;
            s2_bin_r   <= s1_bin_r;
            s2_acc_r   <= s1_acc_r;
            s2_first_r <= s1_first_r;
            s2_emit_r  <= s1_emit_r;
            s2_last_r  <= s1_last_r;
            s2_n_r     <= s1_n_r;
        end
    end

    // Stage 3 accumulate; the first frame of a run overwrites stale RAM contents.
    always_comb begin
        acc_s = s2_first_r ? AW'(s2_p_r) : s2_rd_r + AW'(s2_p_r);
        out_s = s2_acc_r ? PW'(acc_s >> s2_n_r) : s2_p_r;
    end

    // Registered output stage.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_data       <= {PW{1'b0}};
            o_data_valid <= 1'b0;
            o_data_last  <= 1'b0;
        end else if (adv_s) begin
            o_data_valid <= s2_valid_r && s2_emit_r;
            o_data_last  <= s2_valid_r && s2_emit_r && s2_last_r;
            if (s2_valid_r && s2_emit_r) begin
                o_data <= out_s;
            end
        end
    end

    // Accumulator RAM write port.
    always_ff @(posedge i_clk) begin
        if (adv_s && s2_valid_r && s2_acc_r) begin
            mem_r[s2_bin_r] <= acc_s;
        end
    end

endmodule

// File: tb/tb_fft_power_avg.sv
// Bench for fft_power_avg: vector table plus hand sequences, outputs checked
// against a queue of expected {power, last} records.
module tb_fft_power_avg;

    localparam int DW = 16;
    localparam int FL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        din_valid, din_last, din_ready;
    logic        mode;
    logic [2:0]  avg;
    logic [31:0] dout;
    logic        dout_valid, dout_last, dout_ready, ferr;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    fft_power_avg #(.DW(DW), .FRAME_LEN(FL), .MAX_AVG_LOG2(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_data_valid(din_valid),
        .i_data_last(din_last), .o_data_ready(din_ready), .i_mode(mode),
        .i_avg_log2(avg), .o_data(dout), .o_data_valid(dout_valid),
        .o_data_last(dout_last), .i_data_ready(dout_ready), .o_frame_err(ferr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pw(input longint re, input longint im);
        return 32'(re * re + im * im);
    endfunction

    task automatic push(input logic [31:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        sb_q.push_back(e);
    endtask

    // Output monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (ferr === 1'b1) err_cnt++;
        if (rst_n && dout_valid && dout_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got 0x%0h, expected no output", dout);
            end else begin
                e = sb_q.pop_front();
                chk("out_data", dout, e.d);
                chk("out_last", {31'd0, dout_last}, {31'd0, e.l});
            end
        end
    end

    task automatic drive(input logic [15:0] re, input logic [15:0] im, input logic last);
        int w;
        din = {im, re};
        din_last = last;
        din_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!din_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!din_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: o_data_ready=0, expected 1");
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        int err0;
        logic [31:0] exp_cl[8];
        longint s;

        tbl[0] = '{16'd3,    16'd4,    1'b0, 32'd25};
        tbl[1] = '{16'h8000, 16'h8000, 1'b0, 32'h8000_0000};
        tbl[2] = '{16'h7FFF, 16'h8000, 1'b0, 32'h7FFF_0001};
        tbl[3] = '{16'd0,    16'd0,    1'b0, 32'd0};
        tbl[4] = '{16'hFFFF, 16'h0001, 1'b0, 32'd2};
        tbl[5] = '{16'd100,  16'hFF38, 1'b0, 32'd50000};
        tbl[6] = '{16'h8000, 16'd0,    1'b0, 32'h4000_0000};
        tbl[7] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h7FFE_0002};

        rst_n = 1'b0; din = 32'd0; din_valid = 1'b0; din_last = 1'b0;
        mode = 1'b0; avg = 3'd0; dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_data", dout, 32'd0);
        chk("rst_last", {31'd0, dout_last}, 32'd0);
        chk("rst_ferr", {31'd0, ferr}, 32'd0);
        chk("rst_ready", {31'd0, din_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Latency: 3 -> 4 -> 25 appears on the third edge counting the accept edge.
        push(32'd25, 1'b0);
        drive(16'd3, 16'd4, 1'b0);
        lat = 1;
        while (!dout_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        for (int i = 1; i < FL; i++) begin
            push(32'd0, i == FL - 1);
            drive(16'd0, 16'd0, i == FL - 1);
        end
        drain();

        // Passthrough vector table.
        for (int i = 0; i < 8; i++) begin
            push(tbl[i].exp, tbl[i].last);
            drive(tbl[i].re, tbl[i].im, tbl[i].last);
        end
        drain();

        // Back-to-back with downstream stall.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    push(pw(i + 1, 2 * i), i == 7);
                    drive(16'(i + 1), 16'(2 * i), i == 7);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                dout_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_ready_low", {31'd0, din_ready}, 32'd0);
                    @(posedge clk);
                    #1;
                end
                dout_ready = 1'b1;
            end
        join
        drain();

        // Early i_data_last at bin 5, then a clean frame from bin 0.
        err0 = err_cnt;
        for (int b = 0; b < 6; b++) begin
            push(pw(b, 1), b == 5);
            drive(16'(b), 16'd1, b == 5);
        end
        drain();
        chk("frame_err_pulse", 32'(err_cnt - err0), 32'd1);
        for (int b = 0; b < FL; b++) begin
            push(pw(b, 5), b == FL - 1);
            drive(16'(b), 16'd5, b == FL - 1);
        end
        drain();
        chk("frame_err_resync", 32'(err_cnt - err0), 32'd1);

        // Mode raised mid-frame stays passthrough until the boundary.
        avg = 3'd2;
        for (int b = 0; b < FL; b++) begin
            if (b == 4) mode = 1'b1;
            push(pw(b, b), b == FL - 1);
            drive(16'(b), 16'(b), b == FL - 1);
        end
        // Four averaged frames, only the last produces output.
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < FL; k++) begin
                if (f == 3) push(32'((10 * k * k) >> 2), k == FL - 1);
                drive(f < 2 ? 16'(k) : 16'd0, f < 2 ? 16'd0 : 16'(2 * k), k == FL - 1);
            end
        end
        drain();
        mode = 1'b0;
        for (int b = 0; b < FL; b++) begin
            push(pw(b + 7, 3), b == FL - 1);
            drive(16'(b + 7), 16'd3, b == FL - 1);
        end
        drain();

        // avg_log2 = 7 clamps to 4 -> 16 frames, divide by 16.
        for (int k = 0; k < FL; k++) begin
            s = 0;
            for (int f = 0; f < 16; f++) s += longint'((k + f) * (k + f) + f * f);
            exp_cl[k] = 32'(s >> 4);
        end
        mode = 1'b1;
        avg = 3'd7;
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < FL; k++) begin
                if (f == 15) push(exp_cl[k], k == FL - 1);
                drive(16'(k + f), 16'(f), k == FL - 1);
            end
        end
        drain();

        // Reset during frame 2 of a 4-frame average.
        avg = 3'd2;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FL; k++) drive(16'(k + 1), 16'd1, k == FL - 1);
        end
        for (int k = 0; k < 3; k++) drive(16'd9, 16'd9, 1'b0);
        rst_n = 1'b0;
        mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", {31'd0, dout_valid}, 32'd0);
        chk("midrst_data", dout, 32'd0);
        chk("midrst_last", {31'd0, dout_last}, 32'd0);
        chk("midrst_ferr", {31'd0, ferr}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(32'd25, 1'b0);
        drive(16'd3, 16'd4, 1'b0);
        for (int i = 1; i < FL; i++) begin
            push(pw(i, 0), i == FL - 1);
            drive(16'(i), 16'd0, i == FL - 1);
        end
        drain();
        chk("frame_err_total", 32'(err_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
